// File: rtl/niosii_system_sysid_checker.sv
// System-ID checker: an Avalon-MM read master that fetches the system ID
// (address 0) and generation timestamp (address 1) from the sysid slave,
// compares both against build-time constants and reports pass, mismatch
// or bus timeout. Every output is registered.
module niosii_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1490576770,
  parameter int unsigned TIMEOUT_CYCLES     = 1024,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [2:0]  dbg_state
);

  // Read handshake: a transfer completes on the rising edge where
  // avm_read=1 and avm_waitrequest=0; avm_readdata is valid in that same
  // cycle. While avm_waitrequest=1 the master holds avm_read and
  // avm_address unchanged. At most one read is ever outstanding.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_ID = 3'd1,
    S_RD_TS = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Counter wide enough to hold TIMEOUT_CYCLES-1.
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_q,     state_d;
  logic          auto_pend_q, auto_pend_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          read_q,      read_d;
  logic          addr_q,      addr_d;
  logic          busy_q,      busy_d;
  logic          done_q,      done_d;
  logic          id_ok_q,     id_ok_d;
  logic          ts_ok_q,     ts_ok_d;
  logic          pass_q,      pass_d;
  logic          timeout_q,   timeout_d;
  logic [31:0]   id_value_q,  id_value_d;
  logic [31:0]   ts_value_q,  ts_value_d;

  // Next-state and next-output logic for the check sequence.
  always_comb begin
    state_d     = state_q;
    auto_pend_d = 1'b0;  // auto-start request lives for one cycle only
    cnt_d       = cnt_q;
    read_d      = read_q;
    addr_d      = addr_q;
    busy_d      = busy_q;
    done_d      = done_q;
    id_ok_d     = id_ok_q;
    ts_ok_d     = ts_ok_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    id_value_d  = id_value_q;
    ts_value_d  = ts_value_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start || (state_q == S_IDLE && AUTO_START && auto_pend_q)) begin
          state_d   = S_RD_ID;
          read_d    = 1'b1;
          addr_d    = 1'b0;
          busy_d    = 1'b1;
          cnt_d     = '0;
          done_d    = 1'b0;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end

      S_RD_ID, S_RD_TS: begin
        if (!avm_waitrequest) begin
          if (state_q == S_RD_ID) begin
            id_value_d = avm_readdata;
            state_d    = S_RD_TS;
            addr_d     = 1'b1;
            cnt_d      = '0;
          end else begin
            ts_value_d = avm_readdata;
            state_d    = S_CHECK;
            read_d     = 1'b0;
            addr_d     = 1'b0;
          end
        end else if (cnt_q == CNT_LAST) begin
          // This is the final allowed stalled cycle: abandon the read.
          state_d   = S_DONE;
          read_d    = 1'b0;
          addr_d    = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          pass_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_CHECK: begin
        id_ok_d = (id_value_q == EXPECTED_ID);
        ts_ok_d = (ts_value_q == EXPECTED_TIMESTAMP);
        pass_d  = (id_value_q == EXPECTED_ID) &&
                  (ts_value_q == EXPECTED_TIMESTAMP);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
        read_d  = 1'b0;
        addr_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any read on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      auto_pend_q <= 1'b1;
      cnt_q       <= '0;
      read_q      <= 1'b0;
      addr_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      id_ok_q     <= 1'b0;
      ts_ok_q     <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      id_value_q  <= '0;
      ts_value_q  <= '0;
    end else begin
      state_q     <= state_d;
      auto_pend_q <= auto_pend_d;
      cnt_q       <= cnt_d;
      read_q      <= read_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      id_ok_q     <= id_ok_d;
      ts_ok_q     <= ts_ok_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      id_value_q  <= id_value_d;
      ts_value_q  <= ts_value_d;
    end
  end

  assign avm_read    = read_q;
  assign avm_address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Directed bench for the system-ID checker with a small sysid slave model
// (programmable data words and per-read stall lengths) and a scoreboard of
// expected result vectors.
module tb_niosii_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1490576770;
  localparam int          TO     = 16;
  localparam int          W      = 69;  // {done,pass,id_ok,ts_ok,timeout,id,ts}

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        busy, done, id_ok, ts_ok, pass, timeout;
  logic [31:0] id_value, ts_value;
  logic [2:0]  dbg_state;

  // Slave model controls
  logic [31:0] id_word, ts_word;
  logic        stuck_id, stuck_ts;
  int          stall_cfg;
  int          stall_left = 0;

  // Monitor outputs
  int          reads = 0;
  int          viol  = 0;
  logic        prev_stall = 1'b0;
  logic        prev_addr  = 1'b0;

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  logic [W-1:0] exp_q[$];

  niosii_system_sysid_checker #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (TO),
    .AUTO_START         (1'b1)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (waitrequest),
    .avm_readdata    (readdata),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .pass            (pass),
    .timeout         (timeout),
    .id_value        (id_value),
    .ts_value        (ts_value),
    .dbg_state       (dbg_state)
  );

  // Clock
  always #5 clock = ~clock;

  // Sysid slave model: zero-latency data, optional stalls per read
  assign readdata    = avm_address ? ts_word : id_word;
  assign waitrequest = (stuck_id && !avm_address) || (stuck_ts && avm_address) ||
                       (stall_left != 0);

  always @(posedge clock) begin
    if (reset || !avm_read || !waitrequest) stall_left <= stall_cfg;
    else if (stall_left != 0)               stall_left <= stall_left - 1;
  end

  // Monitor: count accepted reads and check address/read hold while stalled
  always @(negedge clock) begin
    if (!reset && avm_read && !waitrequest) reads++;
    if (prev_stall && !reset && !timeout && !(avm_read && avm_address == prev_addr))
      viol++;
    prev_stall = !reset && avm_read && waitrequest;
    prev_addr  = avm_address;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] observed();
    return {done, pass, id_ok, ts_ok, timeout, id_value, ts_value};
  endfunction

  function automatic logic [W-1:0] model(input logic [31:0] id, input logic [31:0] ts);
    logic io, to;
    io = (id == EXP_ID);
    to = (ts == EXP_TS);
    return {1'b1, io && to, io, to, 1'b0, id, ts};
  endfunction

  task automatic sb_check(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, W'(exp_q.size()), W'(1));
    end else begin
      e = exp_q.pop_front();
      check(tag, observed(), e);
    end
  endtask

  // Waits (bounded) for done; returns the number of edges waited.
  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(posedge clock);
      @(negedge clock);
      cyc++;
    end while (!done && cyc < 200);
    if (!done) check({tag, "_budget"}, W'(done), W'(1));
  endtask

  // Pulses start for one edge; done must already be cleared afterwards.
  task automatic start_pulse(input string tag);
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    check({tag, "_done_clear"}, W'(done), W'(0));
  endtask

  initial begin
    int cyc;
    int r0;

    reset     = 1'b1;
    start     = 1'b0;
    id_word   = EXP_ID;
    ts_word   = EXP_TS;
    stuck_id  = 1'b0;
    stuck_ts  = 1'b0;
    stall_cfg = 0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_results", observed(), '0);
    check("rst_bus", W'({avm_read, avm_address, busy}), W'(0));
    check("rst_state", W'(dbg_state), W'(0));

    // 1: auto-start after reset release, clean slave
    r0 = reads;
    exp_q.push_back(model(id_word, ts_word));
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("t1_busy_rd_id", W'({busy, avm_read, avm_address}), W'(3'b110));
    wait_done("t1", cyc);
    check("t1_latency", W'(cyc + 1), W'(4));
    check("t1_reads", W'(reads - r0), W'(2));
    sb_check("t1_result");
    check("t1_idle_bus", W'({busy, avm_read}), W'(0));

    // 2: timestamp mismatch
    ts_word = 32'h1234_5678;
    exp_q.push_back(model(id_word, ts_word));
    start_pulse("t2");
    wait_done("t2", cyc);
    check("t2_latency", W'(cyc + 1), W'(4));
    sb_check("t2_result");

    // 3: five stall cycles on each read
    ts_word   = EXP_TS;
    stall_cfg = 5;
    r0 = reads;
    exp_q.push_back(model(id_word, ts_word));
    start_pulse("t3");
    wait_done("t3", cyc);
    check("t3_latency", W'(cyc + 1), W'(14));
    check("t3_reads", W'(reads - r0), W'(2));
    check("t3_hold", W'(viol), W'(0));
    sb_check("t3_result");

    // 3b: ID off by one, timestamp correct
    stall_cfg = 0;
    id_word   = 32'd1;
    exp_q.push_back(model(id_word, ts_word));
    start_pulse("t3b");
    wait_done("t3b", cyc);
    sb_check("t3b_result");

    // 4: waitrequest stuck in RD_ID -> timeout, earlier captures retained
    id_word  = EXP_ID;
    stuck_id = 1'b1;
    r0 = reads;
    exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1, EXP_TS});
    start_pulse("t4");
    wait_done("t4", cyc);
    check("t4_latency", W'(cyc + 1), W'(TO + 1));
    check("t4_reads", W'(reads - r0), W'(0));
    check("t4_bus", W'({avm_read, busy}), W'(0));
    sb_check("t4_result");
    stuck_id = 1'b0;

    // 4b: stuck in RD_TS -> ID captured, timestamp keeps old value
    stuck_ts = 1'b1;
    ts_word  = 32'hCAFE_F00D;
    exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, EXP_ID, EXP_TS});
    start_pulse("t4b");
    wait_done("t4b", cyc);
    check("t4b_latency", W'(cyc + 1), W'(TO + 2));
    sb_check("t4b_result");
    stuck_ts = 1'b0;
    ts_word  = EXP_TS;

    // 5: reset pulsed in RD_TS, auto-start reruns
    start_pulse("t5");
    @(posedge clock);
    @(negedge clock);
    check("t5_in_rd_ts", W'({dbg_state, avm_read, avm_address}), W'({3'd2, 1'b1, 1'b1}));
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("t5_rst_results", observed(), '0);
    check("t5_rst_bus", W'({avm_read, avm_address, busy}), W'(0));
    r0 = reads;
    exp_q.push_back(model(id_word, ts_word));
    reset = 1'b0;
    wait_done("t5", cyc);
    check("t5_latency", W'(cyc), W'(4));
    check("t5_reads", W'(reads - r0), W'(2));
    sb_check("t5_result");

    // 6: start held through the busy phase is ignored
    r0 = reads;
    exp_q.push_back(model(id_word, ts_word));
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (i == 0) check("t6_done_clear", W'(done), W'(0));
    end
    start = 1'b0;
    check("t6_done_n4", W'(done), W'(1));
    sb_check("t6_result");
    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
    end
    check("t6_stay_done", W'({done, dbg_state, avm_read}), W'({1'b1, 3'd4, 1'b0}));
    check("t6_reads", W'(reads - r0), W'(2));

    check("hold_overall", W'(viol), W'(0));
    check("sb_drained", W'(exp_q.size()), W'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
